// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: base-relative word array with programmable wait states.
// Define DMEM_BYTE_LANE_EN to add the byte_en port and LDRB/STRB lane accesses.
module dmem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       alu_res,
    input  logic [DATA_W-1:0] val_rm,
`ifdef DMEM_BYTE_LANE_EN
    input  logic              byte_en,
`endif
    output logic [DATA_W-1:0] mem_res,
    output logic              ready,
    output logic              addr_err
);

    localparam int LB = $clog2(DATA_W / 8);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
`ifdef DMEM_BYTE_LANE_EN
    logic              byte_q, byte_d;
`endif
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [31:0]       offset;
    logic [31:0]       word_idx;
    logic [IW-1:0]     idx;
    logic              oor;
    logic [DATA_W-1:0] rd_word, rd_data, wr_word;
    logic              we;

    // Decode is done on the latched address so mid-access input changes have no effect.
    always_comb begin
        offset   = addr_q - 32'(BASE_ADDR);
        word_idx = offset >> LB;
        oor      = (addr_q < 32'(BASE_ADDR)) || (word_idx >= 32'(DEPTH));
        idx      = word_idx[IW-1:0];
        rd_word  = mem_q[idx];
    end

    always_comb begin
        rd_data = rd_word;
        wr_word = wdata_q;
`ifdef DMEM_BYTE_LANE_EN
        if (byte_q) begin
            rd_data = DATA_W'(rd_word[{offset[LB-1:0], 3'b000} +: 8]);
            wr_word = rd_word;
            wr_word[{offset[LB-1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
`ifdef DMEM_BYTE_LANE_EN
            byte_q  <= 1'b0;
`endif
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
`ifdef DMEM_BYTE_LANE_EN
            byte_q  <= byte_d;
`endif
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // The array is not reset; a write only happens on the BUSY->DONE edge, which reset cancels.
    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wr_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
`ifdef DMEM_BYTE_LANE_EN
        byte_d  = byte_q;
`endif
        res_d   = res_q;
        err_d   = err_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_r_en || mem_w_en) begin
                    addr_d  = alu_res;
                    wdata_d = val_rm;
                    wr_d    = mem_w_en;
`ifdef DMEM_BYTE_LANE_EN
                    byte_d  = byte_en;
`endif
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    we      = wr_q && !oor;
                    res_d   = (wr_q || oor) ? '0 : rd_data;
                    err_d   = oor;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        mem_res  = res_q;
        addr_err = err_q;
        unique case (state_q)
            IDLE:    ready = !(mem_r_en || mem_w_en);
            BUSY:    ready = 1'b0;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule
